sram_responder: RTL and testbench
=================================

# sram_responder

Synchronous single-port SRAM responder that serves the CPU-side SRAM-like interface (en / byte-wen / addr / wdata → rdata). It sits on the memory side of `mycpu_top` and backs either the instruction or the data port. It holds a local word-addressed memory, applies byte-lane writes, returns read data one cycle after the final request cycle, and inserts a programmable number of wait states through a `stall` output. That output drives the core's `i_stall`/`d_stall`.

## Interface
- `ADDR_W`, 12: word-address width; the memory holds 2^ADDR_W 32-bit words.
- `LATENCY`, 0: wait states per access, legal range 0..15.

- `clk`  input  1  rising-edge clock.
- `resetn`  input  1  asynchronous active-low reset.
- `sram_en`  input  1  request valid.
- `sram_wen`  input  4  byte write enables; `sram_wen[i]` writes byte lane i. 0 means read.
- `sram_addr`  input  32  byte address; bits [1:0] are ignored.
- `sram_wdata`  input  32  write data.
- `sram_rdata`  output  32  registered read data.
- `stall`  output  1  request not yet complete; the core holds its request while this is high.
- `err`  output  1  one-cycle pulse flagging an out-of-range access.

## Operation
- Word index is `sram_addr[ADDR_W+1:2]`. The access is out of range when `sram_addr[31:ADDR_W+2]` is nonzero.
- **Write** (any `sram_wen` bit set): only the enabled byte lanes of the indexed word are updated. `sram_rdata` holds its previous value.
- **Read** (`sram_wen` = 0): `sram_rdata` is loaded with the indexed word.
- **Out-of-range access:**
  - The write is suppressed.
  - A read loads `sram_rdata` with 0.
  - `err` is set to 1 for exactly the cycle in which the result would be visible.
- **`LATENCY` = 0:** no state machine. Every cycle with `sram_en` = 1 performs the access at that clock edge. `stall` is constant 0.
- **`LATENCY` > 0:** two-state FSM, IDLE and BUSY, with a 4-bit counter `cnt`.
  - **IDLE, `sram_en` = 1:**
    - Capture wen, addr and wdata.
    - Set `cnt` = LATENCY-1 and go to BUSY.
    - No memory access happens on this edge.
  - **IDLE, `sram_en` = 0:** stay in IDLE.
  - **BUSY, `cnt` != 0:** decrement `cnt`.
  - **BUSY, `cnt` = 0:**
    - Perform the captured access at this edge.
    - Go to IDLE.
    - `sram_en` is ignored throughout BUSY, because the core is still presenting the same request.
  - `stall` is combinational: `resetn & ((IDLE & sram_en) | (BUSY & cnt != 0))`.
- Memory contents are not reset. No other state exists.

## Timing
- **Reset values:**
  - `sram_rdata` = 0 and `err` = 0.
  - The FSM is in IDLE with `cnt` = 0.
  - `stall` is forced to 0 while `resetn` is low.
- **Latency rule:** a request first presented in cycle N is stalled for exactly LATENCY cycles (N .. N+LATENCY-1).
  - `stall` is low in cycle N+LATENCY.
  - The access happens at the end of cycle N+LATENCY.
  - `sram_rdata` and `err` are valid in cycle N+LATENCY+1.
  - `sram_rdata` holds that value until the next completed read.
- **`LATENCY` = 0:** back-to-back requests complete one per cycle, and each read's data appears on the following cycle.
- **`LATENCY` > 0:** a new request is accepted in the first IDLE cycle after completion. Minimum issue interval is LATENCY+1 cycles.
- **Reset mid-BUSY:**
  - The FSM returns to IDLE immediately.
  - The pending access is dropped: no write, no `err`.
  - `stall` drops asynchronously.
- `err` is a pulse. It returns to 0 on the next edge unless another out-of-range access completes on that edge.
- `LATENCY` outside 0..15 is illegal and produces undefined behaviour.

## Test plan
- **Full-word write then read, `LATENCY`=0:**
  - Write 0x1122_3344 to address 0x10 with wen=4'b1111.
  - Next cycle, read 0x10 → `sram_rdata`=0x1122_3344 one cycle later; `stall` stays 0.
- **Byte-lane write:**
  - Starting from 0x1122_3344 at 0x10, write 0xAABB_CCDD with wen=4'b0010.
  - Read 0x10 → 0x1122_CC44.
  - Then write wen=4'b1001 with 0xEE00_00FF and read → 0xEE22_CCFF.
- **`LATENCY`=3 read:**
  - Hold the read of 0x10 until `stall` falls.
  - `stall` is high for exactly 3 cycles and low in the 4th.
  - `sram_rdata`=0x1122_3344 in the 5th cycle.
  - The next request is accepted in the 5th cycle.
- **Out-of-range, `ADDR_W`=12:**
  - Write 0xFFFF_FFFF to 0x0001_0000 → `err` pulses for 1 cycle, and word 0 is unchanged (read of 0x0 returns its old value).
  - Read 0x0001_0000 → `sram_rdata`=0 and `err`=1.
- **Reset mid-operation, `LATENCY`=4:**
  - Issue a write of 0xDEAD_BEEF to 0x20, and assert `resetn`=0 on the second stall cycle.
  - `stall` goes to 0 immediately and `sram_rdata` reads 0.
  - After release, a read of 0x20 returns its prior contents.
- **Back-to-back streaming reads, `LATENCY`=0:**
  - Read 0x0, 0x4, 0x8 and 0xC in consecutive cycles, preloaded with 1, 2, 3, 4.
  - `sram_rdata` shows 1, 2, 3, 4 on consecutive cycles, each one cycle behind its address.

Source files
------------

// File: rtl/sram_responder.sv
// Word-addressed SRAM model for the CPU-side SRAM-like interface.
// Supports byte-lane writes, registered read data, out-of-range flagging and LATENCY wait states.
module sram_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        stall,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  logic              acc_fire;
  logic [3:0]        acc_wen;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] word_idx;
  logic              oor;
  logic              unused_addr_bits;

  logic [31:0] mem [DEPTH];

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  generate
    if (LATENCY == 0) begin : g_direct
      // Zero wait states: every enabled cycle completes at its own edge.
      assign acc_fire  = resetn & sram_en;
      assign acc_wen   = sram_wen;
      assign acc_addr  = sram_addr;
      assign acc_wdata = sram_wdata;
      assign stall     = 1'b0;
    end else begin : g_fsm
      state_e      state_q, state_d;
      logic [3:0]  cnt_q, cnt_d;
      logic [3:0]  wen_q, wen_d;
      logic [31:0] addr_q, addr_d;
      logic [31:0] wdata_q, wdata_d;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          wen_q   <= 4'd0;
          addr_q  <= 32'd0;
          wdata_q <= 32'd0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          wen_q   <= wen_d;
          addr_q  <= addr_d;
          wdata_q <= wdata_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
          IDLE: begin
            if (sram_en) begin
              wen_d   = sram_wen;
              addr_d  = sram_addr;
              wdata_d = sram_wdata;
              cnt_d   = 4'(LATENCY - 1);
              state_d = BUSY;
            end
          end
          BUSY: begin
            // The core keeps presenting the same request, so sram_en is ignored here.
            if (cnt_q != 4'd0) begin
              cnt_d = cnt_q - 4'd1;
            end else begin
              state_d = IDLE;
            end
          end
        endcase
      end

      assign acc_fire  = (state_q == BUSY) && (cnt_q == 4'd0);
      assign acc_wen   = wen_q;
      assign acc_addr  = addr_q;
      assign acc_wdata = wdata_q;
      assign stall     = resetn & (((state_q == IDLE) & sram_en) |
                                   ((state_q == BUSY) & (cnt_q != 4'd0)));
    end
  endgenerate

  assign word_idx         = acc_addr[ADDR_W+1:2];
  assign oor              = |acc_addr[31:ADDR_W+2];
  assign unused_addr_bits = ^acc_addr[1:0];

  always_ff @(posedge clk) begin
    if (acc_fire && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i]) begin
          mem[word_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Out-of-range reads return zero; writes leave rdata untouched.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (acc_fire) begin
      err_d = oor;
      if (acc_wen == 4'b0000) begin
        rdata_d = oor ? 32'd0 : mem[word_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign sram_rdata = rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: one zero-latency and one three-wait-state instance
// driven by directed and random requests, compared against a word-array reference model.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, en3;
  logic [3:0]  wen0, wen3;
  logic [31:0] addr0, addr3, wdata0, wdata3;
  logic [31:0] rdata0, rdata3;
  logic        stall0, stall3, err0, err3;

  int check_count = 0;
  int error_count = 0;

  // Index 0 models the LATENCY=0 instance, index 1 the LATENCY=3 instance.
  logic [31:0] ref_mem [2][16];
  logic [31:0] exp_rdata [2];

  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(12), .LATENCY(0)) u_lat0 (
    .clk(clk), .resetn(rst_n), .sram_en(en0), .sram_wen(wen0), .sram_addr(addr0),
    .sram_wdata(wdata0), .sram_rdata(rdata0), .stall(stall0), .err(err0)
  );

  sram_responder #(.ADDR_W(12), .LATENCY(3)) u_lat3 (
    .clk(clk), .resetn(rst_n), .sram_en(en3), .sram_wen(wen3), .sram_addr(addr3),
    .sram_wdata(wdata3), .sram_rdata(rdata3), .stall(stall3), .err(err3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one completed access; in-range test addresses stay within words 0..15.
  task automatic modelAccess(input int d, input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic exp_err);
    int w;
    w = int'(addr[5:2]);
    if (addr[31:14] != 18'd0) begin
      exp_err = 1'b1;
      if (wen == 4'd0) exp_rdata[d] = 32'd0;
    end else begin
      exp_err = 1'b0;
      if (wen == 4'd0) begin
        exp_rdata[d] = ref_mem[d][w];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (wen[i]) ref_mem[d][w][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  endtask

  task automatic applyStimulus(input int d, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata);
    logic exp_err;
    if (d == 0) begin
      en0 = 1'b1; wen0 = wen; addr0 = addr; wdata0 = wdata;
      #1;
      checkOutput("l0_stall", 32'(stall0), 32'd0);
      tick;
      en0 = 1'b0;
      modelAccess(0, wen, addr, wdata, exp_err);
      checkOutput("l0_rdata", rdata0, exp_rdata[0]);
      checkOutput("l0_err", 32'(err0), 32'(exp_err));
    end else begin
      en3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wdata;
      #1;
      for (int c = 0; c < 3; c++) begin
        checkOutput("l3_stall_hi", 32'(stall3), 32'd1);
        if (c == 1) checkOutput("l3_err_pulse_end", 32'(err3), 32'd0);
        if (c == 2) checkOutput("l3_rdata_hold", rdata3, exp_rdata[1]);
        tick;
      end
      checkOutput("l3_stall_lo", 32'(stall3), 32'd0);
      tick;
      en3 = 1'b0;
      modelAccess(1, wen, addr, wdata, exp_err);
      checkOutput("l3_rdata", rdata3, exp_rdata[1]);
      checkOutput("l3_err", 32'(err3), 32'(exp_err));
    end
  endtask

  initial begin
    logic [3:0]  r_wen;
    logic [31:0] r_addr;
    int          r_d;

    rst_n = 1'b0;
    en0 = 1'b0; wen0 = 4'd0; addr0 = 32'd0; wdata0 = 32'd0;
    en3 = 1'b1; wen3 = 4'd0; addr3 = 32'd0; wdata3 = 32'd0;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    tick;
    tick;
    checkOutput("rst_rdata0", rdata0, 32'd0);
    checkOutput("rst_err0", 32'(err0), 32'd0);
    checkOutput("rst_rdata3", rdata3, 32'd0);
    checkOutput("rst_err3", 32'(err3), 32'd0);
    checkOutput("rst_stall3_forced", 32'(stall3), 32'd0);
    en3 = 1'b0;
    rst_n = 1'b1;
    tick;

    // Preload words 0..15 in both instances.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = (i < 4) ? 32'(i + 1) : ((i == 4) ? 32'h1122_3344 : $urandom);
      applyStimulus(0, 4'hF, 32'(i * 4), v);
      applyStimulus(1, 4'hF, 32'(i * 4), v);
    end

    applyStimulus(0, 4'h0, 32'h10, 32'd0);
    checkOutput("plan_full_word", rdata0, 32'h1122_3344);
    applyStimulus(0, 4'b0010, 32'h10, 32'hAABB_CCDD);
    applyStimulus(0, 4'h0, 32'h10, 32'd0);
    checkOutput("plan_byte_lane1", rdata0, 32'h1122_CC44);
    applyStimulus(0, 4'b1001, 32'h10, 32'hEE00_00FF);
    applyStimulus(0, 4'h0, 32'h10, 32'd0);
    checkOutput("plan_byte_lane03", rdata0, 32'hEE22_CCFF);

    applyStimulus(1, 4'h0, 32'h10, 32'd0);
    checkOutput("plan_l3_read", rdata3, 32'h1122_3344);

    applyStimulus(0, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF);
    applyStimulus(0, 4'h0, 32'h0, 32'd0);
    checkOutput("plan_oor_no_write", rdata0, 32'd1);
    applyStimulus(0, 4'h0, 32'h0001_0000, 32'd0);
    checkOutput("plan_oor_read_err", 32'(err0), 32'd1);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 4'h0, 32'(k * 4), 32'd0);
      checkOutput("plan_stream", rdata0, 32'(k + 1));
    end

    // Reset on the second stall cycle drops the pending write.
    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h20; wdata3 = 32'hDEAD_BEEF;
    #1;
    checkOutput("rmid_stall_first", 32'(stall3), 32'd1);
    tick;
    checkOutput("rmid_stall_second", 32'(stall3), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_stall_drop", 32'(stall3), 32'd0);
    checkOutput("rmid_rdata3", rdata3, 32'd0);
    checkOutput("rmid_err3", 32'(err3), 32'd0);
    checkOutput("rmid_rdata0", rdata0, 32'd0);
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    en3 = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    checkOutput("rmid_idle_after", 32'(stall3), 32'd0);
    tick;
    applyStimulus(1, 4'h0, 32'h20, 32'd0);

    for (int n = 0; n < 300; n++) begin
      r_d    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      r_wen  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      r_addr = ($urandom_range(0, 4) == 0) ? ($urandom | 32'h0001_0000)
                                           : {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      applyStimulus(r_d, r_wen, r_addr, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
